// File: rtl/rv_pkg.sv
// Shared RISC-V pipeline definitions: widths, writeback queue depth and
// the writeback source selector used by the arbitration logic.
package rv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_AW       = 5;
  localparam int NUM_REGS     = 32;
  localparam int LQ_ENTRIES   = 2;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LQ   = 2'd2
  } wb_src_e;

  // x0 is hardwired to zero, so a result aimed at it never writes the file.
  function automatic logic writes_reg(input logic valid, input reg_addr_t rd);
    return valid && (rd != '0);
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Bus between the pipeline (master) and the writeback stage (slave):
// result inputs, issue tracking, hazard queries and the register file write port.
interface wb_stage_if #(parameter int XLEN = rv_pkg::XLEN_DEFAULT);
  import rv_pkg::*;

  logic            alu_valid;
  reg_addr_t       alu_rd;
  logic [XLEN-1:0] alu_wdata;

  logic            lng_valid;
  reg_addr_t       lng_rd;
  logic [XLEN-1:0] lng_wdata;
  logic            lng_ready;

  logic            iss_valid;
  reg_addr_t       iss_rd;

  reg_addr_t       rs1;
  reg_addr_t       rs2;
  logic            rs1_busy;
  logic            rs2_busy;

  logic            rf_we;
  reg_addr_t       rf_rd;
  logic [XLEN-1:0] rf_wdata;

  modport master (
    output alu_valid, alu_rd, alu_wdata,
    output lng_valid, lng_rd, lng_wdata,
    input  lng_ready,
    output iss_valid, iss_rd,
    output rs1, rs2,
    input  rs1_busy, rs2_busy,
    input  rf_we, rf_rd, rf_wdata
  );

  modport slave (
    input  alu_valid, alu_rd, alu_wdata,
    input  lng_valid, lng_rd, lng_wdata,
    output lng_ready,
    input  iss_valid, iss_rd,
    input  rs1, rs2,
    output rs1_busy, rs2_busy,
    output rf_we, rf_rd, rf_wdata
  );

endinterface

// File: rtl/wb_lq.sv
// Small FIFO that parks long-latency results while the ALU owns the
// register file write port. in_ready depends only on the registered count.
module wb_lq
  import rv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int DEPTH = LQ_ENTRIES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  reg_addr_t       in_rd,
  input  logic [XLEN-1:0] in_wdata,
  output logic            in_ready,
  input  logic            pop,
  output logic            head_valid,
  output reg_addr_t       head_rd,
  output logic [XLEN-1:0] head_wdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]   count;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  reg_addr_t       rd_mem   [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];
  logic            push;
  logic            do_pop;

  assign in_ready   = (count < CW'(DEPTH));
  assign head_valid = (count != '0);
  assign push       = in_valid && in_ready;
  assign do_pop     = pop && head_valid;
  assign head_rd    = rd_mem[rd_ptr];
  assign head_wdata = data_mem[rd_ptr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= in_rd;
      data_mem[wr_ptr] <= in_wdata;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: arbitrates ALU and queued long results onto a registered
// register-file write port and tracks registers with long writes in flight.
module wb_stage
  import rv_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int LQ_DEPTH = LQ_ENTRIES
) (
  input  logic       clk,
  input  logic       rst_n,
  wb_stage_if.slave  bus
);

  wb_src_e             sel;
  logic                lq_pop;
  logic                lq_head_valid;
  reg_addr_t           lq_head_rd;
  logic [XLEN-1:0]     lq_head_wdata;
  logic                rf_from_lq;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;

  wb_lq #(
    .XLEN  (XLEN),
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (bus.lng_valid),
    .in_rd      (bus.lng_rd),
    .in_wdata   (bus.lng_wdata),
    .in_ready   (bus.lng_ready),
    .pop        (lq_pop),
    .head_valid (lq_head_valid),
    .head_rd    (lq_head_rd),
    .head_wdata (lq_head_wdata)
  );

  // ALU results cannot stall, so they always win the write port.
  always_comb begin
    sel = SRC_NONE;
    if (bus.alu_valid)      sel = SRC_ALU;
    else if (lq_head_valid) sel = SRC_LQ;
  end

  assign lq_pop = (sel == SRC_LQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rf_we    <= 1'b0;
      bus.rf_rd    <= '0;
      bus.rf_wdata <= '0;
      rf_from_lq   <= 1'b0;
    end else begin
      rf_from_lq <= (sel == SRC_LQ);
      case (sel)
        SRC_ALU: begin
          bus.rf_we    <= writes_reg(1'b1, bus.alu_rd);
          bus.rf_rd    <= bus.alu_rd;
          bus.rf_wdata <= bus.alu_wdata;
        end
        SRC_LQ: begin
          bus.rf_we    <= writes_reg(1'b1, lq_head_rd);
          bus.rf_rd    <= lq_head_rd;
          bus.rf_wdata <= lq_head_wdata;
        end
        default: begin
          bus.rf_we <= 1'b0;
        end
      endcase
    end
  end

  // A new issue to the same rd overrides the clear from the older writeback.
  always_comb begin
    busy_nxt = busy;
    if (bus.rf_we && rf_from_lq) busy_nxt[bus.rf_rd] = 1'b0;
    if (writes_reg(bus.iss_valid, bus.iss_rd)) busy_nxt[bus.iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  assign bus.rs1_busy = (bus.rs1 != '0) && busy[bus.rs1];
  assign bus.rs2_busy = (bus.rs2 != '0) && busy[bus.rs2];

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a reference model of the long-result queue
// feeds a scoreboard of expected register-file writes.
module tb_wb_stage;
  import rv_pkg::*;

  localparam int XL = XLEN_DEFAULT;

  typedef struct packed {
    logic [4:0]    rd;
    logic [XL-1:0] data;
  } wr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  wb_stage_if #(.XLEN(XL)) bus ();

  wb_stage #(.XLEN(XL), .LQ_DEPTH(LQ_ENTRIES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  wr_t sbq[$];
  wr_t modelLq[$];
  wr_t pend[$];
  int  total = 0;
  int  bad   = 0;

  task automatic checkOutput(input string tag, input logic [XL-1:0] obs, input logic [XL-1:0] expd);
    total++;
    assert (obs === expd) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expd);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [XL-1:0] awd,
                               input logic lv, input logic [4:0] lrd, input logic [XL-1:0] lwd,
                               input logic iv, input logic [4:0] ird,
                               input logic [4:0] r1, input logic [4:0] r2);
    bus.alu_valid = av;  bus.alu_rd = ard;  bus.alu_wdata = awd;
    bus.lng_valid = lv;  bus.lng_rd = lrd;  bus.lng_wdata = lwd;
    bus.iss_valid = iv;  bus.iss_rd = ird;
    bus.rs1 = r1;        bus.rs2 = r2;
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0, 5'd0, r1, r2);
  endtask

  // Model decides the write for this edge, then the DUT write is scored after it.
  task automatic tick(output bit accepted);
    bit  readyM;
    wr_t e;
    readyM = (modelLq.size() < 2);
    checkOutput("lng_ready", {31'd0, bus.lng_ready}, {31'd0, readyM});
    if (bus.alu_valid) begin
      if (bus.alu_rd != 5'd0) sbq.push_back('{rd: bus.alu_rd, data: bus.alu_wdata});
    end else if (modelLq.size() > 0) begin
      e = modelLq.pop_front();
      if (e.rd != 5'd0) sbq.push_back(e);
    end
    accepted = bus.lng_valid && readyM;
    if (accepted) modelLq.push_back('{rd: bus.lng_rd, data: bus.lng_wdata});
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checkOutput("rf_we", {31'd0, bus.rf_we}, 32'd1);
      checkOutput("rf_rd", {27'd0, bus.rf_rd}, {27'd0, e.rd});
      checkOutput("rf_wdata", bus.rf_wdata, e.data);
    end else begin
      checkOutput("rf_we_idle", {31'd0, bus.rf_we}, 32'd0);
    end
  endtask

  initial begin
    bit acc;
    bit sawStall;

    idle(5'd5, 5'd0);
    #2;
    $display("[TB] reset checks");
    checkOutput("rst_rf_we", {31'd0, bus.rf_we}, 32'd0);
    checkOutput("rst_rf_rd", {27'd0, bus.rf_rd}, 32'd0);
    checkOutput("rst_rf_wdata", bus.rf_wdata, 32'd0);
    checkOutput("rst_lng_ready", {31'd0, bus.lng_ready}, 32'd1);
    checkOutput("rst_rs1_busy", {31'd0, bus.rs1_busy}, 32'd0);
    #10 rst_n = 1'b1;

    $display("[TB] ALU write");
    applyStimulus(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick(acc);
    idle(5'd0, 5'd0);
    tick(acc);
    checkOutput("hold_rf_rd", {27'd0, bus.rf_rd}, 32'd5);
    checkOutput("hold_rf_wdata", bus.rf_wdata, 32'h1234);

    $display("[TB] long write clears busy");
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd7, 5'd7, 5'd0);
    tick(acc);
    checkOutput("busy7_set", {31'd0, bus.rs1_busy}, 32'd1);
    applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd7, 32'hDEAD, 1'b0, 5'd0, 5'd7, 5'd0);
    tick(acc);
    checkOutput("busy7_queued", {31'd0, bus.rs1_busy}, 32'd1);
    idle(5'd7, 5'd0);
    tick(acc);
    checkOutput("busy7_rf_stage", {31'd0, bus.rs1_busy}, 32'd1);
    tick(acc);
    checkOutput("busy7_cleared", {31'd0, bus.rs1_busy}, 32'd0);

    $display("[TB] ALU writes do not clear busy");
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd20, 5'd20, 5'd0);
    tick(acc);
    applyStimulus(1'b1, 5'd20, 32'h55, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd20, 5'd0);
    tick(acc);
    idle(5'd20, 5'd0);
    tick(acc);
    checkOutput("busy20_after_alu", {31'd0, bus.rs1_busy}, 32'd1);

    $display("[TB] ALU priority and queue backpressure");
    pend.push_back('{rd: 5'd14, data: 32'hB000});
    pend.push_back('{rd: 5'd15, data: 32'hB001});
    pend.push_back('{rd: 5'd16, data: 32'hB002});
    sawStall = 1'b0;
    for (int k = 0; k < 20 && (k < 4 || pend.size() > 0 || modelLq.size() > 0); k++) begin
      applyStimulus(k < 4, 5'(10 + k), 32'(32'hA000 + k),
                    pend.size() > 0,
                    (pend.size() > 0) ? pend[0].rd : 5'd0,
                    (pend.size() > 0) ? pend[0].data : 32'd0,
                    1'b0, 5'd0, 5'd0, 5'd0);
      if (!bus.lng_ready) sawStall = 1'b1;
      tick(acc);
      if (acc) void'(pend.pop_front());
    end
    checkOutput("stall_seen", {31'd0, sawStall}, 32'd1);
    checkOutput("pending_drained", 32'(pend.size()), 32'd0);

    $display("[TB] rd zero results");
    applyStimulus(1'b1, 5'd0, 32'hCAFE, 1'b1, 5'd0, 32'hBEEF, 1'b0, 5'd0, 5'd0, 5'd0);
    tick(acc);
    idle(5'd0, 5'd0);
    tick(acc);
    tick(acc);
    checkOutput("x0_lng_ready", {31'd0, bus.lng_ready}, 32'd1);

    $display("[TB] reissue wins over clear");
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd9, 5'd9, 5'd9);
    tick(acc);
    applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 5'd9, 5'd9);
    tick(acc);
    idle(5'd9, 5'd9);
    tick(acc);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd9, 5'd9, 5'd9);
    tick(acc);
    checkOutput("busy9_reissue", {31'd0, bus.rs1_busy}, 32'd1);
    idle(5'd9, 5'd9);
    tick(acc);
    checkOutput("busy9_held", {31'd0, bus.rs1_busy}, 32'd1);
    checkOutput("busy9_rs2", {31'd0, bus.rs2_busy}, 32'd1);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 5'd21, 32'h21, 1'b1, 5'd22, 32'h22, 1'b1, 5'd3, 5'd3, 5'd0);
    tick(acc);
    applyStimulus(1'b1, 5'd23, 32'h23, 1'b1, 5'd24, 32'h24, 1'b0, 5'd0, 5'd3, 5'd0);
    tick(acc);
    checkOutput("busy3_before_rst", {31'd0, bus.rs1_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_rf_we", {31'd0, bus.rf_we}, 32'd0);
    checkOutput("midrst_busy3", {31'd0, bus.rs1_busy}, 32'd0);
    modelLq.delete();
    sbq.delete();
    idle(5'd3, 5'd0);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) tick(acc);
    checkOutput("postrst_busy3", {31'd0, bus.rs1_busy}, 32'd0);
    checkOutput("postrst_lng_ready", {31'd0, bus.lng_ready}, 32'd1);

    checkOutput("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register data width.
REQ-002 SHALL have parameter LQ_DEPTH, default 2, meaning long-result queue entries (fixed at 2).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports alu_valid/alu_rd/alu_wdata  input  1/5/XLEN  single-cycle ALU result, no backpressure.
REQ-006 SHALL have ports lng_valid/lng_rd/lng_wdata  input  1/5/XLEN  long-latency (load, mul/div) result.
REQ-007 SHALL have port lng_ready  output  1  queue can accept a long result this cycle.
REQ-008 SHALL have ports iss_valid/iss_rd  input  1/5  long-latency op issued, destination rd.
REQ-009 SHALL have ports rs1/rs2  input  5/5  decode source registers.
REQ-010 SHALL have ports rs1_busy/rs2_busy  output  1/1  source has a pending long write.
REQ-011 SHALL have ports rf_we/rf_rd/rf_wdata  output  1/5/XLEN  registered write port to register file.

Function
REQ-012 SHALL register rf_we, rf_rd, rf_wdata each cycle; register file write occurs one edge later.
REQ-013 SHALL give ALU priority: alu_valid high -> rf_* load ALU result at next edge, queue head held.
REQ-014 SHALL, with alu_valid low and queue non-empty, load queue head into rf_* and pop it at the same edge.
REQ-015 SHALL, with no source, load rf_we=0 and hold rf_rd/rf_wdata.
REQ-016 SHALL force rf_we=0 for rd==0 from either source; an rd==0 long result is still accepted and popped.
REQ-017 SHALL drive lng_ready = (count < 2) from registered count only, no combinational path from alu_valid.
REQ-018 SHALL enqueue on lng_valid && lng_ready; minimum long latency: accept edge N, rf_* at N+1, regfile write at N+2.
REQ-019 SHALL support simultaneous push and pop when count==2 is not the case; count==1 with push+pop stays 1.
REQ-020 SHALL ignore lng_valid while lng_ready=0; no data dropped or overwritten.
REQ-021 SHALL keep busy[31:1] scoreboard; iss_valid with iss_rd!=0 sets busy[iss_rd] at next edge.
REQ-022 SHALL clear busy[rf_rd] at the edge where rf_we is high and rf_* came from the queue (tracked by registered flag).
REQ-023 SHALL let set win over clear for the same register in the same cycle.
REQ-024 SHALL leave busy unchanged on ALU writes, including ALU writes to a busy register.
REQ-025 SHALL hold a re-issued busy rd set until the first long writeback clears it; WAW avoidance is upstream's duty.
REQ-026 SHALL drive rsX_busy = busy[rsX] combinationally; rsX==0 -> 0.

Reset
REQ-027 SHALL on rst_n low asynchronously clear rf_we, rf_rd, rf_wdata, queue count/pointers, busy[31:1] and source flag to 0.
REQ-028 SHALL discard queued results and pending busy bits on reset mid-operation; lng_ready=1 after reset release.

Structure
REQ-029 SHALL take XLEN default, register-address width 5 and LQ_DEPTH from shared package rv_pkg.
REQ-030 SHALL implement the queue as sub-module wb_lq (2-entry FIFO, valid/ready in, pop/head out).
REQ-031 SHALL keep scoreboard and arbitration in wb_stage itself.

Verification
REQ-032 SHALL test: alu_valid, rd=5, 0x1234 -> next cycle rf_we=1, rf_rd=5, rf_wdata=0x1234.
REQ-033 SHALL test: iss rd=7, then lng rd=7, 0xDEAD with ALU idle -> rs1=7 busy until edge rf writes 0xDEAD, then 0.
REQ-034 SHALL test: alu_valid held 4 cycles, 3 lng results offered -> lng_ready low after 2 accepted, ALU writes first, queued results written in order after.
REQ-035 SHALL test: ALU rd=0 and lng rd=0 -> rf_we stays 0, queue drains, lng_ready returns 1.
REQ-036 SHALL test: iss rd=9 same cycle as queued rd=9 writeback clear -> busy[9] remains 1.
REQ-037 SHALL test: rst_n low with 2 queued entries and busy[3]=1 -> immediately rf_we=0, rs1=3 not busy, lng_ready=1 after release.
